// File: rtl/if_fetch_stage_if.sv
// IF stage bundle: pipeline control and redirect inputs, IF->ID bus, instruction SRAM
// request and status outputs.
interface if_fetch_stage_if #(
   parameter int unsigned STALL_W     = 6,
   parameter int unsigned IF_TO_ID_WD = 33,
   parameter int unsigned BR_WD       = 33
);
   logic [STALL_W-1:0]     stall;
   logic                   flush;
   logic [31:0]            new_pc;
   logic [BR_WD-1:0]       br_bus;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;
   logic                   fetch_adel;
   logic [31:0]            fetch_cnt;

   // Fetch stage side: consumes control/redirect, drives bus, SRAM request and status.
   modport master (
      input  stall, flush, new_pc, br_bus,
      output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
             fetch_adel, fetch_cnt
   );

   // Pipeline side: supplies control/redirect, observes the fetch stage.
   modport slave (
      output stall, flush, new_pc, br_bus,
      input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
             fetch_adel, fetch_cnt
   );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction SRAM request and
// remembers a branch redirect that arrives while the PC is stalled.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
   parameter int unsigned STALL_W     = 6,
   parameter int unsigned IF_TO_ID_WD = 33,
   parameter int unsigned BR_WD       = 33
) (
   input logic            i_clk,
   input logic            i_rst,
   if_fetch_stage_if.master bus
);

   logic [31:0] r_pc;
   logic        r_ce;
   logic        r_pend_v;
   logic [31:0] r_pend_addr;
   logic [31:0] r_fetch_cnt;

   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic        w_stop;
   logic [31:0] w_next_pc;
   logic        w_adel;

   assign w_br_e    = bus.br_bus[BR_WD-1];
   assign w_br_addr = bus.br_bus[31:0];
   assign w_stop    = bus.stall[0];

   // Next sequential fetch address: live branch beats a remembered one beats pc+4.
   always_comb begin
      w_next_pc = r_pc + 32'd4;
      if (w_br_e) begin
         w_next_pc = w_br_addr;
      end else if (r_pend_v) begin
         w_next_pc = r_pend_addr;
      end
   end

   // PC, valid, pending-redirect and fetch-counter update: rst > flush > run > stall.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc        <= RESET_PC - 32'd4;
         r_ce        <= 1'b0;
         r_pend_v    <= 1'b0;
         r_pend_addr <= 32'd0;
         r_fetch_cnt <= 32'd0;
      end else if (bus.flush) begin
         r_pc     <= bus.new_pc;
         r_ce     <= 1'b1;
         r_pend_v <= 1'b0;
      end else if (!w_stop) begin
         r_pc        <= w_next_pc;
         r_ce        <= 1'b1;
         r_pend_v    <= 1'b0;
         r_fetch_cnt <= r_fetch_cnt + {31'd0, r_ce};
      end else if (w_br_e) begin
         // Stalled: hold the PC but keep the redirect so it is not lost.
         r_pend_v    <= 1'b1;
         r_pend_addr <= w_br_addr;
      end
   end

   assign w_adel = r_ce & (r_pc[1:0] != 2'b00);

   // Registered-only outputs; a misaligned PC is still presented but not fetched.
   always_comb begin
      bus.if_to_id_bus    = {r_ce, r_pc};
      bus.inst_sram_en    = r_ce & ~w_adel;
      bus.inst_sram_wen   = 4'b0000;
      bus.inst_sram_addr  = r_pc;
      bus.inst_sram_wdata = 32'd0;
      bus.fetch_adel      = w_adel;
      bus.fetch_cnt       = r_fetch_cnt;
   end

endmodule
